// File: rtl/queue_bank_pkg.sv
// queue_bank_pkg
//   Shared sizing for the queue bank and the downstream round-robin arbiter.
//   Holds default parameter values and the widths derived from them.
package queue_bank_pkg;

    localparam int QB_QUANTITY  = 4;
    localparam int QB_DATA_BITS = 8;
    localparam int QB_DEPTH     = 4;

    localparam int QB_SEL_BITS  = $clog2(QB_QUANTITY);
    localparam int QB_PTR_BITS  = $clog2(QB_DEPTH);

endpackage

// File: rtl/queue_bank_fifo.sv
// queue_fifo
//   Single synchronous FIFO with registered pointers and occupancy count.
//   Read data is the combinational head word; the caller registers it.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_en, rd_en  write / read requests (already qualified by global enable)
//   din, dout     write data / head word
//   empty, full   decodes of the registered count
module queue_fifo
    import queue_bank_pkg::*;
#(
    parameter int DATA_BITS = QB_DATA_BITS,
    parameter int DEPTH     = QB_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 empty,
    output logic                 full
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]  rd_ptr;
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [PTR_BITS:0]    count;
    logic                 do_rd;
    logic                 do_wr;

    assign empty = (count == '0);
    assign full  = (count == (PTR_BITS+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    // A write into a full queue is allowed when the head leaves at the same
    // edge: rd_ptr == wr_ptr, and the read samples the old contents.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/queue_bank.sv
// queue_bank
//   Bank of independent FIFO queues feeding a round-robin arbiter. The
//   classifier pushes via push/push_sel; the arbiter's selector/out_enb pair
//   pops via pop_sel/pop. One registered word is delivered per granted pop.
// Ports:
//   clk, rst            clock, synchronous active-high reset (beats enb)
//   enb                 global enable; low freezes all queue state
//   push, push_sel      write request and destination queue
//   data_in             word to write
//   pop, pop_sel        read request and source queue
//   buf_empty/buf_full  per-queue occupancy flags
//   data_out, valid_out registered read word and its one-cycle strobe
//   drop                one-cycle pulse for a push discarded by a full queue
module queue_bank
    import queue_bank_pkg::*;
#(
    parameter int QUEUE_QUANTITY = QB_QUANTITY,
    parameter int DATA_BITS      = QB_DATA_BITS,
    parameter int QUEUE_DEPTH    = QB_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enb,
    input  logic                              push,
    input  logic [$clog2(QUEUE_QUANTITY)-1:0] push_sel,
    input  logic [DATA_BITS-1:0]              data_in,
    input  logic                              pop,
    input  logic [$clog2(QUEUE_QUANTITY)-1:0] pop_sel,
    output logic [QUEUE_QUANTITY-1:0]         buf_empty,
    output logic [QUEUE_QUANTITY-1:0]         buf_full,
    output logic [DATA_BITS-1:0]              data_out,
    output logic                              valid_out,
    output logic                              drop
);

    localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);

    logic [DATA_BITS-1:0]      dout_arr [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] wr_en;
    logic [QUEUE_QUANTITY-1:0] rd_en;
    logic                      push_in_range;
    logic                      pop_in_range;
    logic                      pop_ok;
    logic                      push_drop;

    // Selects beyond QUEUE_QUANTITY are possible when it is not a power of 2;
    // such requests are ignored and never reported as drops.
    assign push_in_range = ({1'b0, push_sel} < (SEL_BITS+1)'(QUEUE_QUANTITY));
    assign pop_in_range  = ({1'b0, pop_sel}  < (SEL_BITS+1)'(QUEUE_QUANTITY));

    always_comb begin
        wr_en = '0;
        rd_en = '0;
        if (enb && push && push_in_range) begin
            wr_en[push_sel] = 1'b1;
        end
        if (enb && pop && pop_in_range) begin
            rd_en[pop_sel] = 1'b1;
        end
    end

    assign pop_ok = |(rd_en & ~buf_empty);

    // A full queue still accepts the push when the same queue pops this edge.
    assign push_drop = |(wr_en & buf_full & ~(rd_en & ~buf_empty));

    for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_queue
        queue_fifo #(
            .DATA_BITS (DATA_BITS),
            .DEPTH     (QUEUE_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr_en (wr_en[i]),
            .rd_en (rd_en[i]),
            .din   (data_in),
            .dout  (dout_arr[i]),
            .empty (buf_empty[i]),
            .full  (buf_full[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            drop      <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            drop      <= push_drop;
            if (pop_ok) begin
                data_out <= dout_arr[pop_sel];
            end
        end
    end

endmodule

// File: doc/queue_bank.md
Name: queue_bank

Overview:
- Bank of QUEUE_QUANTITY independent FIFO queues.
- Sits directly upstream of the round-robin arbiter:
  - drives the arbiter's buf_empty vector;
  - consumes its selector/out_enb pair as the pop request.
- The write side is filled by the classifier stage via push/push_sel.
- The read side delivers one registered word per granted pop to the egress stage.

Parameters:
- QUEUE_QUANTITY, 4: number of queues; must be ≥2.
- DATA_BITS, 8: word width.
- QUEUE_DEPTH, 4: entries per queue; must be a power of 2, ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- enb  input  1  global enable; when low, no state changes.
- push  input  1  write request.
- push_sel  input  $clog2(QUEUE_QUANTITY)  destination queue for push.
- data_in  input  DATA_BITS  word to write.
- pop  input  1  read request; wired to the arbiter out_enb.
- pop_sel  input  $clog2(QUEUE_QUANTITY)  queue to read; wired to the arbiter selector.
- buf_empty  output  QUEUE_QUANTITY  bit i high when queue i holds 0 words.
- buf_full  output  QUEUE_QUANTITY  bit i high when queue i holds QUEUE_DEPTH words.
- data_out  output  DATA_BITS  registered read data.
- valid_out  output  1  data_out is valid this cycle.
- drop  output  1  one-cycle pulse: a push was discarded because the target queue was full.

Behaviour:
- Reset:
  - rst is sampled on the clk edge, synchronous and active-high, and has priority over enb.
  - Clears every queue's rd_ptr, wr_ptr and count.
  - Output values after reset: buf_empty = all 1, buf_full = all 0, data_out = 0, valid_out = 0, drop = 0.
  - Reset asserted mid-operation discards all stored words; an in-flight valid_out is cleared in the same edge.
- Per-queue state:
  - rd_ptr and wr_ptr, $clog2(QUEUE_DEPTH) bits each; both wrap naturally modulo QUEUE_DEPTH.
  - count, $clog2(QUEUE_DEPTH)+1 bits, range 0..QUEUE_DEPTH.
- Flags:
  - buf_empty[i] = (count_i == 0); buf_full[i] = (count_i == QUEUE_DEPTH).
  - Both are combinational decodes of the registered counts, so they reflect state after the last edge.
  - The arbiter therefore sees an empty flag the cycle after the pop that emptied a queue.
- Push (enb=1, push=1):
  - If queue[push_sel] is not full: mem[wr_ptr] <= data_in, wr_ptr+1, count+1.
  - If it is full: the word is discarded, nothing changes, and drop=1 next cycle.
- Pop (enb=1, pop=1):
  - If queue[pop_sel] is not empty: data_out <= mem[rd_ptr], valid_out <= 1 next cycle, rd_ptr+1, count-1.
  - If it is empty: the request is ignored, valid_out <= 0, and data_out holds its previous value.
- Latency: pop to valid_out/data_out is exactly 1 cycle. Push to visibility (buf_empty deassert) is 1 cycle. No fall-through path.
- Simultaneous push and pop, different queues: both are performed independently.
- Simultaneous push and pop, same queue:
  - Not empty and not full: both occur, count is unchanged, and the read returns the old head.
  - Empty: the push is performed and the pop is ignored (valid_out=0). The word becomes poppable the next cycle.
  - Full: both occur, count stays QUEUE_DEPTH, no drop. The write uses the slot freed at the same edge, which is legal because rd_ptr==wr_ptr and the read samples the old contents.
- enb=0:
  - push and pop are ignored and pointers and counts hold.
  - valid_out <= 0 and drop <= 0; data_out holds.
- valid_out and drop are single-cycle pulses and are never held across idle cycles.
- Out-of-range push_sel/pop_sel (QUEUE_QUANTITY not a power of 2): the request is ignored; a push is not counted as a drop.

Decomposition:
- Shared defines include file: QUEUE_QUANTITY, DATA_BITS and QUEUE_DEPTH defaults, plus derived widths SEL_BITS and PTR_BITS. The arbiter uses the same file.
- Sub-module queue_fifo: a single synchronous FIFO.
  - Ports: clk, rst, wr_en, rd_en, din, dout, empty, full.
  - Contains its own pointers and count.
- queue_bank:
  - instantiates QUEUE_QUANTITY copies of queue_fifo via generate;
  - decodes push_sel/pop_sel into one-hot wr_en/rd_en;
  - muxes dout by pop_sel and registers it, together with valid_out and drop.

Test Plan:
1. Reset with rst=1 for 2 cycles, then idle -> buf_empty=4'b1111, buf_full=0, valid_out=0, drop=0.
2. Push 0xA1,0xA2 to q2, then pop q2 twice -> buf_empty[2] falls 1 cycle after the first push; reads give data_out=0xA1 then 0xA2 with valid_out=1 one cycle after each pop; buf_empty[2]=1 after the second pop.
3. Push 5 words 0x10..0x14 to q0 (depth 4) -> buf_full[0]=1 after the 4th; drop pulses once for 0x14; subsequent pops return 0x10..0x13 only.
4. Full q1 with simultaneous push 0x55 and pop q1 -> old head returned, count stays 4, no drop; after 4 more pops the last word out is 0x55.
5. Pop an empty q3 -> valid_out=0, data_out unchanged, no pointer change. Separately, push and pop of empty q3 in the same cycle -> valid_out=0 that cycle; a pop on the next cycle returns the pushed word.
6. Fill q0..q3 with distinct words, assert enb=0 with push/pop active -> no state change. Then assert rst mid-stream -> all queues empty and valid_out=0 on the next cycle.
